// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types for the cache-to-memory request/response path.
//   block_data_t          - one main-memory block
//   main_mem_block_addr_t - block address
//   req_type_t            - READ / WRITE
//   mem_ctrl_state_t      - controller sequencing states
//   requester_t           - which cache owns the in-flight request
package mem_ctrl_pkg;

   localparam int unsigned BLOCK_DATA_WIDTH          = 64;
   localparam int unsigned MAIN_MEM_BLOCK_ADDR_WIDTH = 8;

   typedef logic [BLOCK_DATA_WIDTH-1:0]          block_data_t;
   typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } req_type_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } mem_ctrl_state_t;

   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } requester_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: one cache's request/response channel to the memory controller.
//   req_valid/req_type/req_block_addr/req_block_data : cache -> controller
//   req_ready                                         : controller -> cache
//   resp_valid/resp_block_data                        : controller -> cache
//   master = cache side, slave = controller side.
interface mem_ctrl_if;
   import mem_ctrl_pkg::*;

   logic                 req_valid;
   req_type_t            req_type;
   main_mem_block_addr_t req_block_addr;
   block_data_t          req_block_data;
   logic                 req_ready;
   logic                 resp_valid;
   block_data_t          resp_block_data;

   modport master (
      output req_valid, req_type, req_block_addr, req_block_data,
      input  req_ready, resp_valid, resp_block_data
   );

   modport slave (
      input  req_valid, req_type, req_block_addr, req_block_data,
      output req_ready, resp_valid, resp_block_data
   );

endinterface

// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: fixed-priority 2:1 grant, icache over dcache.
//   idle_i           - controller can take a new request
//   icache_valid_i   - icache request pending
//   dcache_valid_i   - dcache request pending
//   icache_ready_o   - icache may be accepted this cycle
//   dcache_ready_o   - dcache may be accepted this cycle
//   accept_o         - a request is accepted at the next edge
//   owner_o          - which cache is accepted
module mem_ctrl_arbiter
   import mem_ctrl_pkg::*;
(
   input  logic       idle_i,
   input  logic       icache_valid_i,
   input  logic       dcache_valid_i,
   output logic       icache_ready_o,
   output logic       dcache_ready_o,
   output logic       accept_o,
   output requester_t owner_o
);

   always_comb begin
      icache_ready_o = idle_i;
      // dcache is only offered a slot when icache is not asking for it
      dcache_ready_o = idle_i & ~icache_valid_i;
      accept_o       = (icache_valid_i & icache_ready_o) |
                       (dcache_valid_i & dcache_ready_o);
      owner_o        = icache_valid_i ? ICACHE : DCACHE;
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises icache/dcache block requests onto a single-port
// synchronous main-memory array and returns a one-cycle response pulse.
//   clk, rst_aL (async low), init (async high) - clock and clears
//   icache, dcache                             - cache request/response channels
//   mm_csb, mm_web, mm_addr, mm_din            - memory command (active-low strobes)
//   mm_dout                                    - memory read data, one cycle after access
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LATENCY       = 4,
   parameter int unsigned N_MAIN_MEM_BLOCKS = 2**MAIN_MEM_BLOCK_ADDR_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rst_aL,
   input  logic                                   init,
   mem_ctrl_if.slave                              icache,
   mem_ctrl_if.slave                              dcache,
   output logic                                   mm_csb,
   output logic                                   mm_web,
   output logic [$clog2(N_MAIN_MEM_BLOCKS)-1:0]   mm_addr,
   output block_data_t                            mm_din,
   input  block_data_t                            mm_dout
);

   localparam int unsigned MM_AW = $clog2(N_MAIN_MEM_BLOCKS);
   localparam int unsigned CW    = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

   mem_ctrl_state_t      state_q, state_d;
   logic [CW-1:0]        cnt_q,   cnt_d;
   requester_t           owner_q, owner_d;
   req_type_t            type_q,  type_d;
   main_mem_block_addr_t addr_q,  addr_d;
   block_data_t          data_q,  data_d;

   logic       i_ready, d_ready, accept;
   requester_t grant;
   block_data_t resp_data;

   mem_ctrl_arbiter u_arb (
      .idle_i         (state_q == IDLE),
      .icache_valid_i (icache.req_valid),
      .dcache_valid_i (dcache.req_valid),
      .icache_ready_o (i_ready),
      .dcache_ready_o (d_ready),
      .accept_o       (accept),
      .owner_o        (grant)
   );

   assign icache.req_ready = i_ready;
   assign dcache.req_ready = d_ready;

   always_ff @(posedge clk or negedge rst_aL or posedge init) begin
      if (!rst_aL || init) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= ICACHE;
         type_q  <= READ;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      type_d  = type_q;
      addr_d  = addr_q;
      data_d  = data_q;

      mm_csb  = 1'b1;
      mm_web  = 1'b1;
      mm_addr = '0;
      mm_din  = '0;

      icache.resp_valid      = 1'b0;
      dcache.resp_valid      = 1'b0;
      icache.resp_block_data = '0;
      dcache.resp_block_data = '0;

      // reads return the array output, writes echo the block just written
      resp_data = (type_q == READ) ? mm_dout : data_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d = grant;
               if (grant == ICACHE) begin
                  type_d = icache.req_type;
                  addr_d = icache.req_block_addr;
                  data_d = icache.req_block_data;
               end else begin
                  type_d = dcache.req_type;
                  addr_d = dcache.req_block_addr;
                  data_d = dcache.req_block_data;
               end
               if (MEM_LATENCY == 0) begin
                  state_d = ACCESS;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ACCESS: begin
            mm_csb  = 1'b0;
            mm_addr = addr_q[MM_AW-1:0];
            if (type_q == WRITE) begin
               mm_web = 1'b0;
               mm_din = data_q;
            end
            state_d = RESP;
         end
         RESP: begin
            if (owner_q == ICACHE) begin
               icache.resp_valid      = 1'b1;
               icache.resp_block_data = resp_data;
            end else begin
               dcache.resp_valid      = 1'b1;
               dcache.resp_block_data = resp_data;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl at MEM_LATENCY 4 and 0.
// Expected responses come from a plain block-array model and the fixed
// accept-to-response timing of the protocol.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic clk, rst_aL, init;
   logic sel;   // 0: latency-4 instance, 1: latency-0 instance

   logic                 iv, dv;
   req_type_t            ityp, dtyp;
   main_mem_block_addr_t iaddr, daddr;
   block_data_t          idata, ddata;

   mem_ctrl_if if_i4 ();
   mem_ctrl_if if_d4 ();
   mem_ctrl_if if_i0 ();
   mem_ctrl_if if_d0 ();

   assign if_i4.req_valid      = iv & ~sel;
   assign if_i4.req_type       = ityp;
   assign if_i4.req_block_addr = iaddr;
   assign if_i4.req_block_data = idata;
   assign if_d4.req_valid      = dv & ~sel;
   assign if_d4.req_type       = dtyp;
   assign if_d4.req_block_addr = daddr;
   assign if_d4.req_block_data = ddata;
   assign if_i0.req_valid      = iv & sel;
   assign if_i0.req_type       = ityp;
   assign if_i0.req_block_addr = iaddr;
   assign if_i0.req_block_data = idata;
   assign if_d0.req_valid      = dv & sel;
   assign if_d0.req_type       = dtyp;
   assign if_d0.req_block_addr = daddr;
   assign if_d0.req_block_data = ddata;

   logic                 csb4, web4, csb0, web0;
   main_mem_block_addr_t maddr4, maddr0;
   block_data_t          din4, din0, dout4, dout0;

   mem_ctrl #(.MEM_LATENCY(4)) u_dut4 (
      .clk(clk), .rst_aL(rst_aL), .init(init),
      .icache(if_i4), .dcache(if_d4),
      .mm_csb(csb4), .mm_web(web4), .mm_addr(maddr4), .mm_din(din4), .mm_dout(dout4)
   );

   mem_ctrl #(.MEM_LATENCY(0)) u_dut0 (
      .clk(clk), .rst_aL(rst_aL), .init(init),
      .icache(if_i0), .dcache(if_d0),
      .mm_csb(csb0), .mm_web(web0), .mm_addr(maddr0), .mm_din(din0), .mm_dout(dout0)
   );

   // attached synchronous single-port arrays, with a preload port
   block_data_t          sram4 [256];
   block_data_t          sram0 [256];
   logic                 pl_we;
   main_mem_block_addr_t pl_addr;
   block_data_t          pl_data;

   always @(posedge clk) begin
      if (pl_we) begin
         sram4[pl_addr] <= pl_data;
         sram0[pl_addr] <= pl_data;
      end else begin
         if (!csb4) begin
            if (!web4) sram4[maddr4] <= din4;
            else       dout4 <= sram4[maddr4];
         end
         if (!csb0) begin
            if (!web0) sram0[maddr0] <= din0;
            else       dout0 <= sram0[maddr0];
         end
      end
   end

   // observed signals of the instance under test
   logic                 o_ir, o_dr, o_irv, o_drv, o_csb, o_web;
   block_data_t          o_ird, o_drd, o_din;
   main_mem_block_addr_t o_addr;

   always_comb begin
      o_ir   = sel ? if_i0.req_ready       : if_i4.req_ready;
      o_dr   = sel ? if_d0.req_ready       : if_d4.req_ready;
      o_irv  = sel ? if_i0.resp_valid      : if_i4.resp_valid;
      o_drv  = sel ? if_d0.resp_valid      : if_d4.resp_valid;
      o_ird  = sel ? if_i0.resp_block_data : if_i4.resp_block_data;
      o_drd  = sel ? if_d0.resp_block_data : if_d4.resp_block_data;
      o_csb  = sel ? csb0   : csb4;
      o_web  = sel ? web0   : web4;
      o_addr = sel ? maddr0 : maddr4;
      o_din  = sel ? din0   : din4;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference memory contents, one copy per instance
   block_data_t ref_mem [2][32];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request, wait (bounded) for its acceptance, then check every
   // cycle until the controller is idle again. Called right after a negedge.
   task automatic serve(input bit is_i, input req_type_t typ, input main_mem_block_addr_t addr,
                        input block_data_t data, input bit hold, output int t_acc);
      int unsigned lat;
      block_data_t exp;
      bit ok;
      lat = sel ? 0 : 4;
      if (is_i) begin iv = 1'b1; ityp = typ; iaddr = addr; idata = data; end
      else      begin dv = 1'b1; dtyp = typ; daddr = addr; ddata = data; end
      if (typ == READ) exp = ref_mem[sel][addr[4:0]];
      else begin exp = data; ref_mem[sel][addr[4:0]] = data; end
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
         #1;
         if (is_i ? o_ir : o_dr) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk1(is_i ? "i_accept" : "d_accept", ok, 1'b1);
      t_acc = -1;
      if (!ok) begin
         if (is_i) iv = 1'b0; else dv = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      t_acc = cyc;
      if (!hold) begin
         if (is_i) iv = 1'b0; else dv = 1'b0;
      end
      for (int k = 0; k <= int'(lat) + 2; k++) begin
         @(negedge clk);
         #1;
         chk1("i_resp_valid", o_irv, is_i && k == int'(lat) + 1);
         chk1("d_resp_valid", o_drv, !is_i && k == int'(lat) + 1);
         chk64("i_resp_data", o_ird, (is_i && k == int'(lat) + 1) ? exp : '0);
         chk64("d_resp_data", o_drd, (!is_i && k == int'(lat) + 1) ? exp : '0);
         chk1("i_ready", o_ir, k == int'(lat) + 2);
         chk1("d_ready", o_dr, (k == int'(lat) + 2) && !iv);
         chk1("mm_csb", o_csb, k != int'(lat));
         if (k == int'(lat)) begin
            chk1("mm_web", o_web, typ == READ);
            chk64("mm_addr", 64'(o_addr), 64'(addr));
            if (typ == WRITE) chk64("mm_din", o_din, data);
         end
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk1({tag, "_i_resp_valid"}, o_irv, 1'b0);
      chk1({tag, "_d_resp_valid"}, o_drv, 1'b0);
      chk64({tag, "_i_resp_data"}, o_ird, '0);
      chk1({tag, "_mm_csb"}, o_csb, 1'b1);
      chk1({tag, "_mm_web"}, o_web, 1'b1);
      chk1({tag, "_i_ready"}, o_ir, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t1, t2, t3;
      int unsigned mode;
      req_type_t rt;
      main_mem_block_addr_t ra;
      block_data_t rd;

      rst_aL = 1'b1; init = 1'b0; sel = 1'b0;
      iv = 1'b0; dv = 1'b0;
      ityp = READ; dtyp = READ; iaddr = '0; daddr = '0; idata = '0; ddata = '0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;

      // reset state
      #2 rst_aL = 1'b0;
      #1;
      chk_quiet("rst");
      chk1("rst_d_ready", o_dr, 1'b1);
      chk64("rst_d_resp_data", o_drd, '0);

      // preload both arrays and the reference model while in reset
      for (int a = 0; a < 32; a++) begin
         @(negedge clk);
         pl_we   = 1'b1;
         pl_addr = main_mem_block_addr_t'(a);
         pl_data = (a == 16) ? 64'hDEADBEEF_CAFEF00D : {$urandom, $urandom};
         ref_mem[0][a] = pl_data;
         ref_mem[1][a] = pl_data;
      end
      @(negedge clk);
      pl_we = 1'b0;
      @(negedge clk);
      rst_aL = 1'b1;
      @(negedge clk);

      // icache read of the preloaded block
      serve(1'b1, READ, 8'h10, '0, 1'b0, t1);

      // dcache write, then read back, back-to-back
      serve(1'b0, WRITE, 8'h02, 64'h1122334455667788, 1'b0, t1);
      serve(1'b0, READ, 8'h02, '0, 1'b0, t2);
      chk64("b2b_spacing", 64'(t2 - t1), 64'd7);

      // simultaneous requests: icache first, dcache on the next idle cycle
      dv = 1'b1; dtyp = READ; daddr = 8'h03;
      serve(1'b1, READ, 8'h07, '0, 1'b0, t1);
      serve(1'b0, READ, 8'h03, '0, 1'b0, t2);
      chk64("both_d_after_i", 64'(t2 - t1), 64'd7);

      // icache held valid starves dcache until it drops
      dv = 1'b1; dtyp = WRITE; daddr = 8'h04; ddata = 64'hA5A5_0000_FFFF_1234;
      serve(1'b1, READ, 8'h05, '0, 1'b1, t1);
      serve(1'b1, READ, 8'h06, '0, 1'b1, t2);
      chk64("starve_i_spacing", 64'(t2 - t1), 64'd7);
      iv = 1'b0;
      serve(1'b0, WRITE, 8'h04, 64'hA5A5_0000_FFFF_1234, 1'b0, t3);
      chk64("starve_d_after_i", 64'(t3 - t2), 64'd7);

      // rst_aL pulse while the request is waiting
      iv = 1'b1; ityp = READ; iaddr = 8'h05;
      #1;
      @(posedge clk);
      #1 iv = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 chk1("inflight_i_ready", o_ir, 1'b0);
      rst_aL = 1'b0;
      #1 chk_quiet("rst_mid");
      @(negedge clk);
      rst_aL = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1 chk_quiet("post_rst");
      end

      // init pulse while a dcache request is waiting
      dv = 1'b1; dtyp = READ; daddr = 8'h09;
      #1;
      @(posedge clk);
      #1 dv = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1 chk1("inflight_d_ready", o_dr, 1'b0);
      init = 1'b1;
      #1 chk_quiet("init_mid");
      @(negedge clk);
      init = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1 chk_quiet("post_init");
      end

      // randomized traffic on the latency-4 instance, then the latency-0 one
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         @(negedge clk);
         for (int n = 0; n < ((s == 0) ? 25 : 15); n++) begin
            mode = $urandom_range(0, 2);
            ra   = main_mem_block_addr_t'($urandom_range(0, 31));
            rd   = {$urandom, $urandom};
            rt   = req_type_t'($urandom_range(0, 1));
            if (mode == 0) begin
               serve(1'b1, READ, ra, '0, 1'b0, t1);
            end else if (mode == 1) begin
               serve(1'b0, rt, ra, rd, 1'b0, t1);
            end else begin
               dv = 1'b1; dtyp = rt; daddr = ra; ddata = rd;
               serve(1'b1, READ, main_mem_block_addr_t'($urandom_range(0, 31)), '0, 1'b0, t1);
               serve(1'b0, rt, ra, rd, 1'b0, t2);
               chk64("rand_both_spacing", 64'(t2 - t1), 64'((s == 0) ? 7 : 3));
            end
         end
      end

      // latency 0: directed read and write/read pair
      serve(1'b1, READ, 8'h10, '0, 1'b0, t1);
      serve(1'b0, WRITE, 8'h02, 64'h0F0E0D0C0B0A0908, 1'b0, t1);
      serve(1'b0, READ, 8'h02, '0, 1'b0, t2);
      chk64("lat0_b2b_spacing", 64'(t2 - t1), 64'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Responder side of the cache-to-memory request/response protocol.
- Accepts block-granular READ/WRITE requests from the icache and dcache request ports; icache has fixed priority.
- Serialises the requests onto one synchronous single-port main-memory block array.
- Returns a one-cycle, latency-sensitive response pulse carrying block data to the cache that issued the request.
- Models main-memory latency with a programmable wait counter.

Parameters:
MEM_LATENCY, 4, wait cycles between request acceptance and the main-memory access cycle (0 allowed)
N_MAIN_MEM_BLOCKS, 2**`MAIN_MEM_BLOCK_ADDR_WIDTH, depth of the attached main-memory array; mm_addr width only

Ports:
clk  in  1  clock
rst_aL  in  1  asynchronous active-low reset
init  in  1  asynchronous active-high clear, identical effect to reset
icache_req_valid  in  1  icache request
icache_req_type  in  req_type_t  READ/WRITE (icache only issues READ)
icache_req_block_addr  in  main_mem_block_addr_t  block address
icache_req_block_data  in  block_data_t  write data (unused for icache)
icache_req_ready  out  1  accept icache request this cycle
icache_resp_valid  out  1  one-cycle response pulse
icache_resp_block_data  out  block_data_t  response block
dcache_req_valid  in  1  dcache request
dcache_req_type  in  req_type_t  READ/WRITE
dcache_req_block_addr  in  main_mem_block_addr_t  block address
dcache_req_block_data  in  block_data_t  write-through block
dcache_req_ready  out  1  accept dcache request this cycle
dcache_resp_valid  out  1  one-cycle response pulse
dcache_resp_block_data  out  block_data_t  response block
mm_csb  out  1  main-memory chip select, active low
mm_web  out  1  main-memory write enable, active low
mm_addr  out  main_mem_block_addr_t  main-memory block address
mm_din  out  block_data_t  main-memory write data
mm_dout  in  block_data_t  main-memory read data, valid the cycle after a read access

Behaviour:
- Reset/init (asynchronous): state=IDLE, counter=0, owner=ICACHE, latched type/addr/data=0. All outputs deassert: resp_valid=0, mm_csb=1, mm_web=1, resp data=0. icache_req_ready=1 while in IDLE.
- Ready rules (combinational from state):
  - icache_req_ready = (state==IDLE).
  - dcache_req_ready = (state==IDLE) & ~icache_req_valid.
  - Consequently an icache request is always accepted whenever the controller is IDLE.
- Acceptance at edge T (valid&ready):
  - Latch owner, type, addr, data.
  - Go to WAIT with counter=MEM_LATENCY-1, or go directly to ACCESS if MEM_LATENCY==0.
  - If both caches are valid in the same cycle, the icache wins; dcache valid must stay held and is accepted in a later IDLE cycle.
- WAIT: decrement the counter each cycle; go to ACCESS on the cycle the counter is 0.
  - Counter width is $clog2(MEM_LATENCY+1), minimum 1.
  - No wrap-around: the counter never decrements below 0.
- ACCESS (1 cycle):
  - mm_csb=0, mm_addr=latched addr.
  - For WRITE: mm_web=0, mm_din=latched data.
  - For READ: mm_web=1.
  - Next state is RESP.
- RESP (1 cycle):
  - Assert <owner>_resp_valid=1; the other cache's resp_valid stays 0.
  - READ: resp_block_data = mm_dout.
  - WRITE: resp_block_data = latched write data (echo); the cache clears its waiting flag from this pulse.
  - Next state is IDLE; no new request is accepted during RESP.
- Latency: accept at edge T → resp_valid high during cycle T+MEM_LATENCY+2. Back-to-back throughput is one request per MEM_LATENCY+3 cycles.
- Requests are never dropped or reordered; only one request is outstanding at a time.
- resp_block_data is 0 whenever the corresponding resp_valid=0.
- Reset mid-operation: the in-flight request is abandoned, no response is issued, state returns to IDLE. A partially completed memory write is not retried.
- A requester changing valid/addr while not ready is ignored; sampling happens only at the accept edge.

Decomposition:
- Shared package (global_defs): req_type_t, main_mem_block_addr_t, block_data_t, `BLOCK_DATA_WIDTH, `MAIN_MEM_BLOCK_ADDR_WIDTH, new mem_ctrl_state_t {IDLE, WAIT, ACCESS, RESP}, requester_t {ICACHE, DCACHE}.
- One natural sub-module: mem_ctrl_arbiter, a fixed-priority 2:1 combinational grant producing both ready signals and the owner select.

Test Plan:
1. MEM_LATENCY=4, memory block 0x10 preloaded with 0xDEADBEEF_CAFEF00D; icache READ addr 0x10 accepted at T → icache_resp_valid=1 only at T+6 with that data, dcache_resp_valid=0 throughout.
2. dcache WRITE addr 0x2 data 0x1122334455667788 → mm_csb=0/mm_web=0 at T+5 with that data; dcache_resp_valid at T+6 echoing it; a following READ addr 0x2 returns 0x1122334455667788.
3. icache and dcache both valid the same cycle → icache accepted; dcache_req_ready=0 until IDLE; dcache accepted at T+7; responses arrive in that order.
4. MEM_LATENCY=0 → ACCESS directly after acceptance; resp_valid at T+2.
5. rst_aL pulsed low while in WAIT → outputs return to reset values immediately and no resp_valid ever follows; icache_req_ready=1 after release.
6. icache_req_valid held high continuously → dcache starves (required priority). Once icache drops, dcache is accepted on the next IDLE cycle.
